// File: rtl/mux_arb_n.sv
// N-channel valid/ready multiplexer with fixed-select or round-robin grant
// and a single registered output stage allowing one word per cycle.
module mux_arb_n #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned N     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N*WIDTH-1:0]     in_data,
    input  logic [N-1:0]           in_valid,
    output logic [N-1:0]           in_ready,
    input  logic [$clog2(N)-1:0]   sel,
    input  logic                   rr_mode,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    output logic [$clog2(N)-1:0]   out_ch,
    input  logic                   out_ready
);

    localparam int unsigned SELW = $clog2(N);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] grant;
    logic [SELW-1:0] idx;
    logic            gnt_valid;
    logic            can_load;
    logic            xfer_in;

    // Grant selection: fixed channel, or first valid channel searching from ptr
    always_comb begin
        grant     = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        if (!rr_mode) begin
            grant     = sel;
            gnt_valid = in_valid[sel];
        end else begin
            // Descending scan so the smallest offset from ptr wins
            for (int k = N - 1; k >= 0; k--) begin
                idx = ptr + SELW'(k);
                if (in_valid[idx]) begin
                    grant     = idx;
                    gnt_valid = 1'b1;
                end
            end
        end
    end

    // Handshake: ready only to the granted channel when the output slot is free
    always_comb begin
        can_load = !out_valid || out_ready;
        xfer_in  = gnt_valid && can_load && !reset;
        in_ready = '0;
        if (xfer_in) begin
            in_ready = N'(1) << grant;
        end
    end

    // Output register stage and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (xfer_in) begin
            out_valid <= 1'b1;
            out_data  <= in_data[32'(grant) * WIDTH +: WIDTH];
            out_ch    <= grant;
            if (rr_mode) begin
                ptr <= grant + SELW'(1);
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed, table-driven bench for mux_arb_n (N=4, WIDTH=64).
module tb_mux_arb_n;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned N     = 4;

    logic               clk;
    logic               reset;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [1:0]         sel;
    logic               rr_mode;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic [1:0]         out_ch;
    logic               out_ready;

    int total = 0;
    int bad   = 0;

    mux_arb_n #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .rr_mode   (rr_mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rr;
        logic [1:0]  sel;
        logic [3:0]  iv;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [1:0]  e_ch;
        logic [63:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, id, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic rr, input logic [1:0] s, input logic [3:0] iv,
                       input logic ordy, input logic [3:0] e_rdy, input logic e_ov,
                       input logic [1:0] e_ch, input logic [63:0] e_data);
        vec_t v;
        v.rst = rst; v.rr = rr; v.sel = s; v.iv = iv; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_ch = e_ch; v.e_data = e_data;
        vecs.push_back(v);
    endtask

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        rr_mode   = 1'b0;
        sel       = 2'd0;
        in_valid  = '0;
        out_ready = 1'b0;
        in_data   = {64'h33, 64'hA5, 64'h11, 64'h10};

        //   rst rr  sel   iv       ordy  e_rdy    ov  ch    data
        // reset, then fixed select of channel 2
        add(1, 0, 2'd2, 4'b1111, 1, 4'b0000, 0, 2'd0, 64'h0);
        add(0, 0, 2'd2, 4'b1111, 1, 4'b0100, 1, 2'd2, 64'hA5);
        // fixed select of an invalid channel: no grant, output drains and stays empty
        add(0, 0, 2'd1, 4'b1101, 1, 4'b0000, 0, 2'd2, 64'hA5);
        add(0, 0, 2'd1, 4'b1101, 1, 4'b0000, 0, 2'd2, 64'hA5);
        // round-robin after reset, all valid: 0,1,2,3,0 back to back
        add(1, 1, 2'd0, 4'b1111, 1, 4'b0000, 0, 2'd0, 64'h0);
        add(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0, 64'h10);
        add(0, 1, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1, 64'h11);
        add(0, 1, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2, 64'hA5);
        add(0, 1, 2'd0, 4'b1111, 1, 4'b1000, 1, 2'd3, 64'h33);
        add(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0, 64'h10);
        // sparse valids: alternate 1,3,1
        add(1, 1, 2'd0, 4'b1010, 1, 4'b0000, 0, 2'd0, 64'h0);
        add(0, 1, 2'd0, 4'b1010, 1, 4'b0010, 1, 2'd1, 64'h11);
        add(0, 1, 2'd0, 4'b1010, 1, 4'b1000, 1, 2'd3, 64'h33);
        add(0, 1, 2'd0, 4'b1010, 1, 4'b0010, 1, 2'd1, 64'h11);
        // backpressure on held word 0x11, then reload with no bubble
        add(0, 1, 2'd0, 4'b1010, 0, 4'b0000, 1, 2'd1, 64'h11);
        add(0, 1, 2'd0, 4'b1010, 0, 4'b0000, 1, 2'd1, 64'h11);
        add(0, 1, 2'd0, 4'b1010, 0, 4'b0000, 1, 2'd1, 64'h11);
        add(0, 1, 2'd0, 4'b1010, 1, 4'b1000, 1, 2'd3, 64'h33);
        // move ptr to 2 with a held word, then reset discards it and search restarts at 0
        add(0, 1, 2'd0, 4'b0010, 1, 4'b0010, 1, 2'd1, 64'h11);
        add(1, 1, 2'd0, 4'b1111, 0, 4'b0000, 0, 2'd0, 64'h0);
        add(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0, 64'h10);
        // fixed-mode transfer leaves ptr at 1
        add(0, 0, 2'd3, 4'b1000, 1, 4'b1000, 1, 2'd3, 64'h33);
        add(0, 1, 2'd3, 4'b1111, 1, 4'b0010, 1, 2'd1, 64'h11);
        // nothing valid: output drains, ch/data hold
        add(0, 1, 2'd0, 4'b0000, 1, 4'b0000, 0, 2'd1, 64'h11);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset     = vecs[i].rst;
            rr_mode   = vecs[i].rr;
            sel       = vecs[i].sel;
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            #1;
            chk("in_ready", i, 64'(in_ready), 64'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            chk("out_valid", i, 64'(out_valid), 64'(vecs[i].e_ov));
            chk("out_ch", i, 64'(out_ch), 64'(vecs[i].e_ch));
            chk("out_data", i, out_data, vecs[i].e_data);
        end

        // Held word must ignore data changes on its source channel until drained
        @(negedge clk);
        reset = 1'b0; rr_mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b0;
        #1;
        chk("seq_rdy_load", 100, 64'(in_ready), 64'(4'b0100));
        @(posedge clk); #1;
        chk("seq_data_load", 100, out_data, 64'hA5);
        chk("seq_ch_load", 100, 64'(out_ch), 64'd2);
        @(negedge clk);
        in_data[2*WIDTH +: WIDTH] = 64'hDEAD;
        #1;
        chk("seq_rdy_stall", 101, 64'(in_ready), 64'(4'b0000));
        @(posedge clk); #1;
        chk("seq_data_hold", 101, out_data, 64'hA5);
        chk("seq_valid_hold", 101, 64'(out_valid), 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("seq_rdy_resume", 102, 64'(in_ready), 64'(4'b0100));
        @(posedge clk); #1;
        chk("seq_data_new", 102, out_data, 64'hDEAD);
        chk("seq_valid_new", 102, 64'(out_valid), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
